// File: rtl/pc_fetch_ctrl_if.sv
// Branch-resolution / fetch-control bundle between the EX/ID stages and the PC sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface pc_fetch_ctrl_if #(
    parameter int PC_W = 9
);
    logic            stall_i;
    logic            pc_sel_i;
    logic [31:0]     br_pc_i;
    logic            halt_i;
    logic            resume_i;
    logic [PC_W-1:0] pc_o;
    logic            inst_req_o;
    logic            flush_ifid_o;
    logic            flush_idex_o;
    logic            halted_o;
    logic            misalign_o;
    logic [15:0]     redirect_cnt_o;

    modport master (
        output stall_i,
        output pc_sel_i,
        output br_pc_i,
        output halt_i,
        output resume_i,
        input  pc_o,
        input  inst_req_o,
        input  flush_ifid_o,
        input  flush_idex_o,
        input  halted_o,
        input  misalign_o,
        input  redirect_cnt_o
    );

    modport slave (
        input  stall_i,
        input  pc_sel_i,
        input  br_pc_i,
        input  halt_i,
        input  resume_i,
        output pc_o,
        output inst_req_o,
        output flush_ifid_o,
        output flush_idex_o,
        output halted_o,
        output misalign_o,
        output redirect_cnt_o
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: owns the program counter, applies EX redirects, drives pipeline flushes,
// runs the halt drain sequence and traps on misaligned redirect targets.
module pc_fetch_ctrl #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
    parameter int              DRAIN_CYC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_ctrl_if.slave ifc
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_TRAP   = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [3:0]      DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [3:0]      drain_cnt_r;
    logic [3:0]      drain_nxt_s;
    logic [15:0]     redirect_cnt_r;
    logic [15:0]     redirect_nxt_s;
    logic            inst_req_s;
    logic            flush_ifid_s;
    logic            flush_idex_s;
    logic            halted_s;
    logic            misalign_s;
    logic            unused_br_hi_s;

    // Saturating 16-bit increment for the redirect counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

    // Instruction targets must be word aligned (no compressed extension).
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Target bits above PC_W are discarded; the fetch address wraps.
    assign unused_br_hi_s = ^ifc.br_pc_i[31:PC_W];

    // State, PC, drain counter and redirect counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RUN;
            pc_r           <= RESET_PC;
            drain_cnt_r    <= 4'd0;
            redirect_cnt_r <= 16'd0;
        end else begin
            state_r        <= state_nxt_s;
            pc_r           <= pc_nxt_s;
            drain_cnt_r    <= drain_nxt_s;
            redirect_cnt_r <= redirect_nxt_s;
        end
    end

    // Next-state and output decode; only RUN flushes depend on live inputs.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        drain_nxt_s    = drain_cnt_r;
        redirect_nxt_s = redirect_cnt_r;
        inst_req_s     = 1'b0;
        flush_ifid_s   = 1'b0;
        flush_idex_s   = 1'b0;
        halted_s       = 1'b0;
        misalign_s     = 1'b0;

        case (state_r)
            ST_RUN: begin
                inst_req_s = 1'b1;
                if (ifc.pc_sel_i) begin
                    // Redirect beats halt and stall: anything younger is wrong-path.
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                    if (is_word_aligned(ifc.br_pc_i)) begin
                        pc_nxt_s       = ifc.br_pc_i[PC_W-1:0];
                        redirect_nxt_s = sat_inc16(redirect_cnt_r);
                    end else begin
                        state_nxt_s = ST_TRAP;
                    end
                end else if (ifc.halt_i) begin
                    flush_ifid_s = 1'b1;
                    state_nxt_s  = ST_DRAIN;
                    drain_nxt_s  = DRAIN_LOAD;
                end else if (ifc.stall_i) begin
                    pc_nxt_s = pc_r;
                end else begin
                    pc_nxt_s = pc_r + PC_STEP;
                end
            end
            ST_DRAIN: begin
                flush_ifid_s = 1'b1;
                if (drain_cnt_r == 4'd0) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    drain_nxt_s = drain_cnt_r - 4'd1;
                end
            end
            ST_HALTED: begin
                halted_s     = 1'b1;
                flush_ifid_s = 1'b1;
                if (ifc.resume_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_TRAP: begin
                misalign_s   = 1'b1;
                flush_ifid_s = 1'b1;
                flush_idex_s = 1'b1;
            end
            default: begin
                // Unreachable encoding: fail safe into the trap state.
                state_nxt_s  = ST_TRAP;
                flush_ifid_s = 1'b1;
                flush_idex_s = 1'b1;
            end
        endcase
    end

    assign ifc.pc_o           = pc_r;
    assign ifc.inst_req_o     = inst_req_s;
    assign ifc.flush_ifid_o   = flush_ifid_s;
    assign ifc.flush_idex_o   = flush_idex_s;
    assign ifc.halted_o       = halted_s;
    assign ifc.misalign_o     = misalign_s;
    assign ifc.redirect_cnt_o = redirect_cnt_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (PC_W=9, RESET_PC=0, DRAIN_CYC=3).
module tb_pc_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_fetch_ctrl_if #(.PC_W(9)) bus ();

    pc_fetch_ctrl #(
        .PC_W      (9),
        .RESET_PC  (9'h000),
        .DRAIN_CYC (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall_i  = 1'b0;
        bus.pc_sel_i = 1'b0;
        bus.br_pc_i  = 32'h0000_0000;
        bus.halt_i   = 1'b0;
        bus.resume_i = 1'b0;
    endtask

    // Aligned redirect used to position the PC; also advances the counter by one.
    task automatic redirect_to(input logic [31:0] tgt);
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = tgt;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.pc_o !== 9'h000 || bus.inst_req_o !== 1'b1 || bus.flush_ifid_o !== 1'b0 ||
            bus.flush_idex_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.misalign_o !== 1'b0 ||
            bus.redirect_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b fi=%b fe=%b h=%b m=%b cnt=%h expected pc=000 req=1 others 0",
                     bus.pc_o, bus.inst_req_o, bus.flush_ifid_o, bus.flush_idex_o,
                     bus.halted_o, bus.misalign_o, bus.redirect_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_increment();
        logic [8:0] exp_pc;
        exp_pc = 9'h000;
        for (int i = 1; i <= 128; i++) begin
            tick();
            exp_pc = exp_pc + 9'd4;
            checks++;
            if (bus.pc_o !== exp_pc) begin
                errors++;
                $display("FAIL increment step %0d: pc=%h expected %h", i, bus.pc_o, exp_pc);
            end
            if (i == 127) begin
                checks++;
                if (bus.pc_o !== 9'h1FC) begin
                    errors++;
                    $display("FAIL increment_top: pc=%h expected 1fc", bus.pc_o);
                end
            end
        end
        checks++;
        if (bus.pc_o !== 9'h000 || bus.redirect_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL increment_wrap: pc=%h cnt=%h expected pc=000 cnt=0000", bus.pc_o, bus.redirect_cnt_o);
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.pc_o !== 9'h020) begin
            errors++;
            $display("FAIL redirect_setup: pc=%h expected 020", bus.pc_o);
        end
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = 32'h0000_0100;
        bus.stall_i  = 1'b1;
        #1;
        checks++;
        if (bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_flush: fi=%b fe=%b expected 1 1", bus.flush_ifid_o, bus.flush_idex_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 9'h100 || bus.redirect_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL redirect_target: pc=%h cnt=%h expected 100 0001", bus.pc_o, bus.redirect_cnt_o);
        end
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = 32'h0000_0304;
        #1;
        checks++;
        if (bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_wrap_flush: fi=%b fe=%b expected 1 1", bus.flush_ifid_o, bus.flush_idex_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 9'h104 || bus.redirect_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL redirect_wrap: pc=%h cnt=%h expected 104 0002", bus.pc_o, bus.redirect_cnt_o);
        end
    endtask

    task automatic test_stall();
        redirect_to(32'h0000_0040);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.pc_o !== 9'h040 || bus.inst_req_o !== 1'b1 ||
                bus.flush_ifid_o !== 1'b0 || bus.flush_idex_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: pc=%h req=%b fi=%b fe=%b expected 040 1 0 0",
                         i, bus.pc_o, bus.inst_req_o, bus.flush_ifid_o, bus.flush_idex_o);
            end
            tick();
        end
        bus.stall_i = 1'b0;
        checks++;
        if (bus.pc_o !== 9'h040 || bus.redirect_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL stall_end: pc=%h cnt=%h expected 040 0003", bus.pc_o, bus.redirect_cnt_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 9'h044) begin
            errors++;
            $display("FAIL stall_release: pc=%h expected 044", bus.pc_o);
        end
    endtask

    task automatic test_halt();
        redirect_to(32'h0000_0080);
        bus.halt_i  = 1'b1;
        bus.stall_i = 1'b1;
        #1;
        checks++;
        if (bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b0 || bus.inst_req_o !== 1'b1) begin
            errors++;
            $display("FAIL halt_flush: fi=%b fe=%b req=%b expected 1 0 1",
                     bus.flush_ifid_o, bus.flush_idex_o, bus.inst_req_o);
        end
        tick();
        clear_inputs();
        // Inputs during drain must be ignored.
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.inst_req_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.pc_o !== 9'h080 ||
                bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b0) begin
                errors++;
                $display("FAIL drain cycle %0d: req=%b h=%b pc=%h fi=%b fe=%b expected 0 0 080 1 0",
                         i, bus.inst_req_o, bus.halted_o, bus.pc_o, bus.flush_ifid_o, bus.flush_idex_o);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.halted_o !== 1'b1 || bus.inst_req_o !== 1'b0 || bus.pc_o !== 9'h080 ||
                bus.flush_ifid_o !== 1'b1) begin
                errors++;
                $display("FAIL halted cycle %0d: h=%b req=%b pc=%h fi=%b expected 1 0 080 1",
                         i, bus.halted_o, bus.inst_req_o, bus.pc_o, bus.flush_ifid_o);
            end
            tick();
        end
        clear_inputs();
        bus.resume_i = 1'b1;
        tick();
        bus.resume_i = 1'b0;
        checks++;
        if (bus.halted_o !== 1'b0 || bus.inst_req_o !== 1'b1 || bus.pc_o !== 9'h080 ||
            bus.redirect_cnt_o !== 16'd4) begin
            errors++;
            $display("FAIL resume: h=%b req=%b pc=%h cnt=%h expected 0 1 080 0004",
                     bus.halted_o, bus.inst_req_o, bus.pc_o, bus.redirect_cnt_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 9'h084) begin
            errors++;
            $display("FAIL resume_step: pc=%h expected 084", bus.pc_o);
        end
    endtask

    task automatic test_trap();
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = 32'h0000_0102;
        #1;
        checks++;
        if (bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b1 || bus.misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL trap_entry: fi=%b fe=%b m=%b expected 1 1 0",
                     bus.flush_ifid_o, bus.flush_idex_o, bus.misalign_o);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.misalign_o !== 1'b1 || bus.inst_req_o !== 1'b0 || bus.pc_o !== 9'h084 ||
                bus.redirect_cnt_o !== 16'd4 || bus.halted_o !== 1'b0 ||
                bus.flush_ifid_o !== 1'b1 || bus.flush_idex_o !== 1'b1) begin
                errors++;
                $display("FAIL trap_hold cycle %0d: m=%b req=%b pc=%h cnt=%h h=%b fi=%b fe=%b expected 1 0 084 0004 0 1 1",
                         i, bus.misalign_o, bus.inst_req_o, bus.pc_o, bus.redirect_cnt_o,
                         bus.halted_o, bus.flush_ifid_o, bus.flush_idex_o);
            end
            bus.resume_i = 1'b1;
            tick();
            bus.resume_i = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.misalign_o !== 1'b0 || bus.pc_o !== 9'h000 || bus.inst_req_o !== 1'b1 ||
            bus.redirect_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL trap_async_reset: m=%b pc=%h req=%b cnt=%h expected 0 000 1 0000",
                     bus.misalign_o, bus.pc_o, bus.inst_req_o, bus.redirect_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.pc_o !== 9'h004) begin
            errors++;
            $display("FAIL post_reset_step: pc=%h expected 004", bus.pc_o);
        end
    endtask

    task automatic test_saturate();
        bus.pc_sel_i = 1'b1;
        bus.br_pc_i  = 32'h0000_0010;
        for (int i = 0; i < 65534; i++) tick();
        checks++;
        if (bus.redirect_cnt_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_below: cnt=%h expected fffe", bus.redirect_cnt_o);
        end
        tick();
        checks++;
        if (bus.redirect_cnt_o !== 16'hFFFF || bus.pc_o !== 9'h010) begin
            errors++;
            $display("FAIL sat_reach: cnt=%h pc=%h expected ffff 010", bus.redirect_cnt_o, bus.pc_o);
        end
        bus.br_pc_i = 32'h0000_0020;
        tick();
        clear_inputs();
        checks++;
        if (bus.redirect_cnt_o !== 16'hFFFF || bus.pc_o !== 9'h020) begin
            errors++;
            $display("FAIL sat_hold: cnt=%h pc=%h expected ffff 020", bus.redirect_cnt_o, bus.pc_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        clear_inputs();
        test_reset();
        test_increment();
        test_redirect();
        test_stall();
        test_halt();
        test_trap();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
